// File: rtl/frame_loader_if.sv
// Cell-stream and banked-write bundle between a pattern source, frame_loader
// and the frame-buffer write ports.
//
// Handshake: a cell moves from source to loader on a rising clk edge exactly
// when s_valid and s_ready are both high. s_ready never depends on s_valid.
// The write side has no back-pressure: write_enable is a one-cycle strobe and
// write_addr/write_data/write_buffer_select are valid whenever it is nonzero.
interface frame_loader_if #(
    parameter int ADDR_WIDTH = 2
);
    logic                  s_valid;
    logic                  s_ready;
    logic                  s_data;
    logic [8:0]            write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  write_data;
    logic                  write_buffer_select;

    // Environment side: pattern source plus frame-buffer write ports.
    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  write_enable,
        input  write_addr,
        input  write_data,
        input  write_buffer_select
    );

    // Loader side.
    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output write_enable,
        output write_addr,
        output write_data,
        output write_buffer_select
    );
endinterface

// File: rtl/frame_loader.sv
// frame_loader: takes a raster-order stream of 1-bit cells and scatters each
// one into the nine 3x3-interleaved cell banks. Bank = y_pixel*3 + x_pixel,
// block address = y_block*WIDTH_BLOCKS + x_block, matching the read mapping of
// the generation controller. One frame is loaded per accepted start.
module frame_loader #(
    parameter int ADDR_WIDTH            = 2,
    parameter int WIDTH_BLOCKS          = 2,
    parameter int HEIGHT_BLOCKS         = 2,
    parameter int PIXELS_PER_BLOCK      = 3,
    parameter int PIXEL_COUNTER_WIDTH   = 2,
    parameter int BLOCK_X_COUNTER_WIDTH = 1,
    parameter int BLOCK_Y_COUNTER_WIDTH = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          buffer_select,
    frame_loader_if.slave bus,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PIXEL_COUNTER_WIDTH-1:0] PX_MAX =
        PIXEL_COUNTER_WIDTH'(PIXELS_PER_BLOCK - 1);
    localparam logic [BLOCK_X_COUNTER_WIDTH-1:0] XB_MAX =
        BLOCK_X_COUNTER_WIDTH'(WIDTH_BLOCKS - 1);
    localparam logic [BLOCK_Y_COUNTER_WIDTH-1:0] YB_MAX =
        BLOCK_Y_COUNTER_WIDTH'(HEIGHT_BLOCKS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(WIDTH_BLOCKS);

    state_t state;
    state_t state_next;

    logic [PIXEL_COUNTER_WIDTH-1:0]   x_pixel;
    logic [PIXEL_COUNTER_WIDTH-1:0]   y_pixel;
    logic [BLOCK_X_COUNTER_WIDTH-1:0] x_block;
    logic [BLOCK_Y_COUNTER_WIDTH-1:0] y_block;
    logic [ADDR_WIDTH-1:0]            row_base;

    logic                  s_ready_c;
    logic                  transfer;
    logic                  start_accept;
    logic                  x_end;
    logic                  xb_end;
    logic                  y_end;
    logic                  yb_end;
    logic                  last_cell;
    logic [3:0]            bank_idx;
    logic [ADDR_WIDTH-1:0] block_addr;

    assign bus.s_ready = s_ready_c;
    assign dbg_state   = state;

    // Counter wrap flags; the last cell of a frame is where all four wrap together.
    assign x_end     = (x_pixel == PX_MAX);
    assign xb_end    = (x_block == XB_MAX);
    assign y_end     = (y_pixel == PX_MAX);
    assign yb_end    = (y_block == YB_MAX);
    assign last_cell = x_end & xb_end & y_end & yb_end;

    // Bank is y*3 + x built from a shift and adds so no multiplier is inferred.
    assign bank_idx   = {1'b0, y_pixel, 1'b0} + 4'(y_pixel) + 4'(x_pixel);
    // Row base already carries y_block*WIDTH_BLOCKS, so only x_block is added here.
    assign block_addr = row_base + ADDR_WIDTH'(x_block);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and state-decoded handshake/status outputs.
    always_comb begin
        state_next   = state;
        s_ready_c    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        transfer     = 1'b0;
        start_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready_c = 1'b1;
                busy      = 1'b1;
                transfer  = bus.s_valid;
                if (bus.s_valid && last_cell) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Raster counter chain and row base; advances only on an accepted cell.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            x_pixel  <= '0;
            y_pixel  <= '0;
            x_block  <= '0;
            y_block  <= '0;
            row_base <= '0;
        end else if (transfer) begin
            if (!x_end) begin
                x_pixel <= x_pixel + 1'b1;
            end else begin
                x_pixel <= '0;
                if (!xb_end) begin
                    x_block <= x_block + 1'b1;
                end else begin
                    x_block <= '0;
                    if (!y_end) begin
                        y_pixel <= y_pixel + 1'b1;
                    end else begin
                        y_pixel <= '0;
                        if (!yb_end) begin
                            y_block  <= y_block + 1'b1;
                            row_base <= row_base + ROW_STRIDE;
                        end else begin
                            y_block  <= '0;
                            row_base <= '0;
                        end
                    end
                end
            end
        end
    end

    // Registered write port: one strobe per accepted cell, address/data held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.write_enable        <= '0;
            bus.write_addr          <= '0;
            bus.write_data          <= 1'b0;
            bus.write_buffer_select <= 1'b0;
        end else begin
            if (start_accept) begin
                bus.write_buffer_select <= buffer_select;
            end
            if (transfer) begin
                bus.write_enable <= 9'd1 << bank_idx;
                bus.write_addr   <= block_addr;
                bus.write_data   <= bus.s_data;
            end else begin
                bus.write_enable <= '0;
            end
        end
    end

    // A bank strobe must never hit two banks at once.
    assert property (@(posedge clk) $onehot0(bus.write_enable));

    // The source is only ever offered a slot while a frame is being loaded.
    assert property (@(posedge clk) bus.s_ready |-> busy);

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: a per-cycle driver keeps a raster-index model of the
// frame and queues the write each accepted cell must produce; a forked monitor
// checks the write port every cycle against that queue.
module tb_frame_loader;
    localparam int AW     = 2;
    localparam int WB     = 2;
    localparam int HB     = 2;
    localparam int FW     = WB * 3;
    localparam int FH     = HB * 3;
    localparam int NCELLS = FW * FH;
    localparam int RW     = 1 + AW + 9 + 1;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       buffer_select;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    frame_loader_if #(.ADDR_WIDTH(AW)) bus ();

    frame_loader #(
        .ADDR_WIDTH(AW),
        .WIDTH_BLOCKS(WB),
        .HEIGHT_BLOCKS(HB),
        .PIXELS_PER_BLOCK(3),
        .PIXEL_COUNTER_WIDTH(2),
        .BLOCK_X_COUNTER_WIDTH(1),
        .BLOCK_Y_COUNTER_WIDTH(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .buffer_select(buffer_select),
        .bus(bus.slave),
        .busy(busy),
        .done(done),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state.
    logic [RW-1:0] exp_q[$];
    int            due_q[$];
    int            checks = 0;
    int            errors = 0;

    // Reference model: frame phase, latched buffer and raster cell index.
    int   m_state = M_IDLE;
    logic m_buf   = 1'b0;
    int   m_n     = 0;

    // Per-frame coverage of (bank, addr) pairs.
    int   got_cnt[9][4];
    logic got_val[9][4];
    logic exp_val[9][4];
    int   total_writes;
    int   fw_idx;
    logic directed;
    logic [1:0] idle_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic clear_cov();
        for (int b = 0; b < 9; b++) begin
            for (int a = 0; a < 4; a++) begin
                got_cnt[b][a] = 0;
                got_val[b][a] = 1'b0;
                exp_val[b][a] = 1'b0;
            end
        end
        total_writes = 0;
        fw_idx       = 0;
    endtask

    // One clock of stimulus: apply inputs, check status at the falling edge,
    // advance the model to what the next rising edge should produce.
    task automatic step(input logic v, input logic d, input logic st, input logic bs, input logic rst);
        int x;
        int y;
        int bank;
        int addr;
        logic [AW-1:0] ea;
        logic [8:0]    ewe;
        reset         = rst;
        start         = st;
        buffer_select = bs;
        bus.s_valid   = v;
        bus.s_data    = d;
        @(negedge clk);
        check("s_ready", {31'd0, bus.s_ready}, {31'd0, m_state == M_LOAD});
        check("busy", {31'd0, busy}, {31'd0, m_state != M_IDLE});
        check("done", {31'd0, done}, {31'd0, m_state == M_DONE});
        if (m_state == M_LOAD) check("state_not_idle", {31'd0, dbg_state != idle_code}, 32'd1);
        if (rst) begin
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (st) begin
                    m_state = M_LOAD;
                    m_buf   = bs;
                    m_n     = 0;
                end
                M_LOAD: if (v) begin
                    x    = m_n % FW;
                    y    = m_n / FW;
                    bank = (y % 3) * 3 + (x % 3);
                    addr = (y / 3) * WB + (x / 3);
                    ea   = AW'(addr);
                    ewe  = 9'd1 << bank;
                    exp_q.push_back({m_buf, ea, ewe, d});
                    due_q.push_back(cyc + 1);
                    exp_val[bank][addr] = d;
                    m_n++;
                    if (m_n == NCELLS) m_state = M_DONE;
                end
                default: m_state = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // Every (bank, addr) written exactly once with the model's data.
    task automatic check_cov(input logic bs);
        for (int b = 0; b < 9; b++) begin
            for (int a = 0; a < 4; a++) begin
                check($sformatf("cov_cnt_b%0d_a%0d", b, a), got_cnt[b][a], 1);
                check($sformatf("cov_val_b%0d_a%0d", b, a), {31'd0, got_val[b][a]}, {31'd0, exp_val[b][a]});
            end
        end
        check("total_writes", total_writes, NCELLS);
        check("write_buffer_select", {31'd0, bus.write_buffer_select}, {31'd0, bs});
    endtask

    // mode 0: s_valid held high, 1: random, 2: strict 1-0-1 toggle.
    task automatic run_frame(input logic bs, input int mode, input int mid_start, input int abort_at);
        int   guard;
        logic v;
        logic aborted;
        guard   = 0;
        aborted = 1'b0;
        clear_cov();
        step(1'b0, 1'b0, 1'b1, bs, 1'b0);
        while (m_state != M_IDLE && guard < 400) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = 1'($urandom_range(0, 1));
            else                v = (guard % 2 == 0);
            if (abort_at >= 0 && m_state == M_LOAD && m_n == abort_at) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
                aborted = 1'b1;
            end else begin
                step(v, 1'($urandom_range(0, 1)), guard == mid_start, 1'b0, 1'b0);
            end
            guard++;
        end
        check("frame_in_budget", {31'd0, guard < 400}, 32'd1);
        if (!aborted) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_cov(bs);
        end
    endtask

    initial begin
        clear_cov();
        directed = 1'b0;
        reset = 1'b1; start = 1'b0; buffer_select = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 1'b1;

        // Monitor: compare the write port against the queue every cycle.
        fork
            forever begin
                logic [RW-1:0] rec;
                @(negedge clk);
                check("we_onehot0", {31'd0, $onehot0(bus.write_enable)}, 32'd1);
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    rec = exp_q.pop_front();
                    void'(due_q.pop_front());
                    check("write_rec",
                          {19'd0, bus.write_buffer_select, bus.write_addr, bus.write_enable, bus.write_data},
                          {19'd0, rec});
                    if (directed) begin
                        case (fw_idx)
                            0:  check("cell_0_0", {21'd0, bus.write_enable, bus.write_addr}, {21'd0, 9'h001, 2'd0});
                            3:  check("cell_3_0", {21'd0, bus.write_enable, bus.write_addr}, {21'd0, 9'h001, 2'd1});
                            22: check("cell_4_3", {21'd0, bus.write_enable, bus.write_addr}, {21'd0, 9'h002, 2'd3});
                            35: check("cell_5_5", {21'd0, bus.write_enable, bus.write_addr}, {21'd0, 9'h100, 2'd3});
                            default: ;
                        endcase
                    end
                    fw_idx++;
                end else begin
                    check("we_quiet", {23'd0, bus.write_enable}, 32'd0);
                end
                if (bus.write_enable != 9'd0) begin
                    for (int b = 0; b < 9; b++) begin
                        if (bus.write_enable[b]) begin
                            got_cnt[b][bus.write_addr]++;
                            got_val[b][bus.write_addr] = bus.write_data;
                        end
                    end
                    total_writes++;
                end
            end
        join_none

        // Reset then idle with s_valid high and no start.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_code = dbg_state;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rst_addr", {30'd0, bus.write_addr}, 32'd0);
        check("rst_data", {31'd0, bus.write_data}, 32'd0);
        check("rst_wbs", {31'd0, bus.write_buffer_select}, 32'd0);

        // Full frame, s_valid held high, buffer 1, directed cell checks.
        directed = 1'b1;
        run_frame(1'b1, 0, -1, -1);
        directed = 1'b0;

        // Random throttling with a start re-pulsed mid-frame (buffer_select=0).
        run_frame(1'b1, 1, 10, -1);

        // Strict 1-0-1 throttle into buffer 0.
        run_frame(1'b0, 2, -1, -1);

        // Reset while the 18th cell (index 17) is presented.
        run_frame(1'b1, 0, -1, 17);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_state_idle", {30'd0, dbg_state}, {30'd0, idle_code});
        check("abort_addr", {30'd0, bus.write_addr}, 32'd0);
        check("abort_data", {31'd0, bus.write_data}, 32'd0);
        check("abort_wbs", {31'd0, bus.write_buffer_select}, 32'd0);

        // Fresh frame after the abort starts again at cell (0,0).
        directed = 1'b1;
        run_frame(1'b1, 0, -1, -1);
        directed = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
